// File: rtl/pipe_sequencer.sv
// pipe_sequencer: fetch PC, stage valids, flush/stall/memwait sequencing for a 3-stage core.
// Optional perf counters (flush_count, stall_count) built when PIPE_SEQ_PERF_EN is defined.
module pipe_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_2000,
  parameter int unsigned STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_pip1,
  input  logic        flush_pip2,
  input  logic [31:0] redirect_pc,
  input  logic        load_stall,
  input  logic        imem_valid,
  output logic        imem_req,
  output logic [31:0] pc_if,
  output logic [31:0] pc_ex,
  output logic        valid_ex,
  output logic        valid_wb,
  output logic        stall,
  output logic [15:0] flush_count,
  output logic [15:0] stall_count
);
  typedef enum logic [2:0] {BOOT, RUN, STALL, REDIRECT, MEMWAIT} state_t;
  state_t     state;
  logic [3:0] cnt;
  logic       flush_take;
  assign flush_take = (flush_pip1 | flush_pip2) && state != BOOT;
  assign imem_req   = state == RUN || state == REDIRECT || state == MEMWAIT;
  assign stall      = state == STALL;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= BOOT;
      pc_if    <= RESET_PC;
      pc_ex    <= '0;
      valid_ex <= 1'b0;
      valid_wb <= 1'b0;
      cnt      <= '0;
    end else if (flush_take) begin
      state    <= REDIRECT;
      pc_if    <= redirect_pc & ~32'd3;
      valid_ex <= valid_ex & ~flush_pip1;
      valid_wb <= valid_ex & ~flush_pip2;
    end else begin
      case (state)
        BOOT: state <= RUN;
        STALL: begin
          valid_wb <= 1'b0;
          cnt      <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= RUN;
        end
        REDIRECT: begin
          valid_ex <= 1'b0;
          valid_wb <= valid_ex;
          state    <= RUN;
        end
        default: begin
          // load_stall only counts from RUN; MEMWAIT ignores it
          if (state == RUN && load_stall) begin
            state    <= STALL;
            cnt      <= STALL_CYCLES[3:0];
            valid_wb <= 1'b0;
          end else if (imem_valid) begin
            pc_ex    <= pc_if;
            valid_ex <= 1'b1;
            valid_wb <= valid_ex;
            pc_if    <= pc_if + 32'd4;
            state    <= RUN;
          end else begin
            valid_ex <= 1'b0;
            valid_wb <= valid_ex;
            state    <= MEMWAIT;
          end
        end
      endcase
    end
`ifdef PIPE_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      flush_count <= '0;
      stall_count <= '0;
    end else begin
      if (flush_take && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
      if (state == STALL && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
`else
  assign flush_count = '0;
  assign stall_count = '0;
`endif
endmodule

// File: tb/tb_pipe_sequencer.sv
// tb_pipe_sequencer: directed + random stimulus, reference model feeds a scoreboard queue checked by a monitor.
module tb_pipe_sequencer;
  localparam logic [31:0] RPC = 32'h0000_2000;
  localparam int SC = 2;
  localparam int M_BOOT = 0, M_RUN = 1, M_STALL = 2, M_REDIR = 3, M_MEMW = 4;
  typedef struct packed {
    logic [31:0] pc_if, pc_ex;
    logic vex, vwb, req, stl;
    logic [15:0] fc, sc;
  } exp_t;
  logic clk = 0, rst_n = 0;
  logic flush_pip1 = 0, flush_pip2 = 0, load_stall = 0, imem_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic imem_req, valid_ex, valid_wb, stall;
  logic [31:0] pc_if, pc_ex;
  logic [15:0] flush_count, stall_count;
  int n_tests = 0, n_fail = 0;
  exp_t q[$];
  int m_mode, m_left;
  logic [31:0] m_pc_if, m_pc_ex;
  logic m_vex, m_vwb;
  int m_fc, m_sc;

  pipe_sequencer #(.RESET_PC(RPC), .STALL_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .flush_pip1(flush_pip1), .flush_pip2(flush_pip2),
    .redirect_pc(redirect_pc), .load_stall(load_stall), .imem_valid(imem_valid),
    .imem_req(imem_req), .pc_if(pc_if), .pc_ex(pc_ex), .valid_ex(valid_ex),
    .valid_wb(valid_wb), .stall(stall), .flush_count(flush_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_BOOT; m_pc_if = RPC; m_pc_ex = 0; m_vex = 0; m_vwb = 0;
    m_left = 0; m_fc = 0; m_sc = 0;
  endfunction

  function automatic void model_step();
    logic old_vex;
    old_vex = m_vex;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_mode == M_STALL) m_sc = (m_sc < 65535) ? m_sc + 1 : m_sc;
    if (m_mode == M_BOOT) m_mode = M_RUN;
    else if (flush_pip1 || flush_pip2) begin
      m_fc = (m_fc < 65535) ? m_fc + 1 : m_fc;
      m_pc_if = {redirect_pc[31:2], 2'b00};
      m_vex = flush_pip1 ? 1'b0 : old_vex;
      m_vwb = flush_pip2 ? 1'b0 : old_vex;
      m_mode = M_REDIR;
    end else if (m_mode == M_RUN && load_stall) begin
      m_left = SC; m_vwb = 0; m_mode = M_STALL;
    end else if (m_mode == M_STALL) begin
      m_vwb = 0; m_left--;
      if (m_left == 0) m_mode = M_RUN;
    end else if (m_mode == M_REDIR) begin
      m_vwb = old_vex; m_vex = 0; m_mode = M_RUN;
    end else if (imem_valid) begin
      m_vwb = old_vex; m_pc_ex = m_pc_if; m_vex = 1; m_pc_if = m_pc_if + 4; m_mode = M_RUN;
    end else begin
      m_vwb = old_vex; m_vex = 0; m_mode = M_MEMW;
    end
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.pc_if = m_pc_if; e.pc_ex = m_pc_ex; e.vex = m_vex; e.vwb = m_vwb;
    e.req = m_mode == M_RUN || m_mode == M_REDIR || m_mode == M_MEMW;
    e.stl = m_mode == M_STALL;
`ifdef PIPE_SEQ_PERF_EN
    e.fc = 16'(m_fc); e.sc = 16'(m_sc);
`else
    e.fc = 0; e.sc = 0;
`endif
    return e;
  endfunction

  task automatic cyc(input logic r, input logic f1, input logic f2, input logic [31:0] rp,
                     input logic ls, input logic iv);
    @(negedge clk);
    rst_n = r; flush_pip1 = f1; flush_pip2 = f2; redirect_pc = rp;
    load_stall = ls; imem_valid = iv;
    model_step();
    q.push_back(snap());
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pc_if", pc_if, e.pc_if);
        check("pc_ex", pc_ex, e.pc_ex);
        check("valid_ex", 32'(valid_ex), 32'(e.vex));
        check("valid_wb", 32'(valid_wb), 32'(e.vwb));
        check("imem_req", 32'(imem_req), 32'(e.req));
        check("stall", 32'(stall), 32'(e.stl));
        check("flush_count", 32'(flush_count), 32'(e.fc));
        check("stall_count", 32'(stall_count), 32'(e.sc));
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) cyc(0, 0, 0, 0, 0, 1);
    repeat (4) cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 1, 1, 32'h3007, 0, 1);
    repeat (3) cyc(1, 0, 0, 0, 0, 1);
    repeat (3) cyc(1, 0, 0, 0, 1, 1);
    repeat (2) cyc(1, 0, 0, 0, 0, 1);
    repeat (4) cyc(1, 0, 0, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1, 1);
    cyc(1, 1, 0, 32'h0000_4010, 0, 1);
    repeat (3) cyc(1, 0, 0, 0, 0, 1);
    repeat (2) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 32'h0000_5022, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 32'hFFFF_FFFF, 0, 1);
    repeat (4) cyc(1, 0, 0, 0, 0, 1);
    repeat (400)
      cyc(1, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom,
          $urandom_range(0, 6) == 0, $urandom_range(0, 3) != 0);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1, 1);
    @(negedge clk);
    flush_pip1 = 0; flush_pip2 = 0; load_stall = 0; imem_valid = 1;
    #2 rst_n = 0;
    #1;
    check("async pc_if", pc_if, RPC);
    check("async pc_ex", pc_ex, 0);
    check("async valid_ex", 32'(valid_ex), 0);
    check("async valid_wb", 32'(valid_wb), 0);
    check("async imem_req", 32'(imem_req), 0);
    check("async stall", 32'(stall), 0);
    check("async flush_count", 32'(flush_count), 0);
    check("async stall_count", 32'(stall_count), 0);
    model_step();
    q.push_back(snap());
    cyc(0, 0, 0, 0, 0, 1);
    repeat (4) cyc(1, 0, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard drained", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
